// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store.
// One transaction in flight; a watchdog aborts acks that never arrive.
module mem_port_arbiter #(
    parameter int BIT_WIDTH   = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IREQ,
    input  logic [BIT_WIDTH-1:0] IAD,
    output logic [BIT_WIDTH-1:0] IDT,
    output logic                 ACKI_n,
    input  logic                 DREQ,
    input  logic                 DWRITE,
    input  logic [1:0]           DSIZE,
    input  logic [BIT_WIDTH-1:0] DAD,
    input  logic [BIT_WIDTH-1:0] DWDT,
    output logic [BIT_WIDTH-1:0] DRDT,
    output logic                 ACKD_n,
    output logic [BIT_WIDTH-1:0] MAD,
    output logic [BIT_WIDTH-1:0] MWDT,
    input  logic [BIT_WIDTH-1:0] MRDT,
    output logic                 MREQ,
    output logic                 MWRITE,
    output logic [1:0]           MSIZE,
    input  logic                 MACK_n,
    output logic                 BUS_ERR
);

    typedef enum logic [1:0] {
        IDLE,
        IBUSY,
        DBUSY,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] W_TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] W_WD_MAX   = '1;

    state_t               r_state;
    state_t               w_next;
    logic                 r_last_d;
    logic [CNT_W-1:0]     r_wd;
    logic                 w_gnt_i;
    logic                 w_gnt_d;
    logic                 w_ack_ok;
    logic                 w_tmo;
    logic [BIT_WIDTH-1:0] w_cap;

    // Data wins a conflict unless it was the side granted last.
    logic w_pick_d;
    assign w_pick_d = DREQ && (!IREQ || !r_last_d);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_gnt_i  = 1'b0;
        w_gnt_d  = 1'b0;
        w_ack_ok = 1'b0;
        w_tmo    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_d) begin
                    w_gnt_d = 1'b1;
                    w_next  = DBUSY;
                end else if (IREQ) begin
                    w_gnt_i = 1'b1;
                    w_next  = IBUSY;
                end
            end
            IBUSY, DBUSY: begin
                if (!MACK_n) begin
                    w_ack_ok = 1'b1;
                    w_next   = DONE;
                end else if (r_wd == W_TMO_LAST) begin
                    w_tmo  = 1'b1;
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_cap = w_tmo ? '0 : MRDT;

    always_ff @(posedge clk) begin
        if (!rst) begin
            MREQ     <= 1'b0;
            MWRITE   <= 1'b0;
            MSIZE    <= 2'b00;
            MAD      <= '0;
            MWDT     <= '0;
            IDT      <= '0;
            DRDT     <= '0;
            ACKI_n   <= 1'b1;
            ACKD_n   <= 1'b1;
            BUS_ERR  <= 1'b0;
            r_wd     <= '0;
            r_last_d <= 1'b0;
        end else begin
            if (w_gnt_i) begin
                MREQ     <= 1'b1;
                MAD      <= IAD;
                MWRITE   <= 1'b0;
                MSIZE    <= 2'b00;
                r_last_d <= 1'b0;
            end
            if (w_gnt_d) begin
                MREQ     <= 1'b1;
                MAD      <= DAD;
                MWRITE   <= DWRITE;
                MSIZE    <= DSIZE;
                MWDT     <= DWDT;
                r_last_d <= 1'b1;
            end
            if (w_ack_ok || w_tmo) begin
                MREQ    <= 1'b0;
                BUS_ERR <= w_tmo;
                if (r_state == IBUSY) begin
                    IDT    <= w_cap;
                    ACKI_n <= 1'b0;
                end else begin
                    DRDT   <= w_cap;
                    ACKD_n <= 1'b0;
                end
            end else if ((r_state == IBUSY || r_state == DBUSY)
                         && r_wd != W_WD_MAX) begin
                r_wd <= r_wd + 1'b1;
            end
            if (r_state == DONE) begin
                ACKI_n  <= 1'b1;
                ACKD_n  <= 1'b1;
                BUS_ERR <= 1'b0;
                r_wd    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the bench plays the memory side.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        IREQ, DREQ, DWRITE, MACK_n;
    logic [1:0]  DSIZE;
    logic [31:0] IAD, DAD, DWDT, MRDT;
    logic [31:0] IDT, DRDT, MAD, MWDT;
    logic        ACKI_n, ACKD_n, MREQ, MWRITE, BUS_ERR;
    logic [1:0]  MSIZE;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.BIT_WIDTH(32), .TIMEOUT_CYC(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .IREQ(IREQ), .IAD(IAD), .IDT(IDT), .ACKI_n(ACKI_n),
        .DREQ(DREQ), .DWRITE(DWRITE), .DSIZE(DSIZE), .DAD(DAD),
        .DWDT(DWDT), .DRDT(DRDT), .ACKD_n(ACKD_n),
        .MAD(MAD), .MWDT(MWDT), .MRDT(MRDT), .MREQ(MREQ),
        .MWRITE(MWRITE), .MSIZE(MSIZE), .MACK_n(MACK_n),
        .BUS_ERR(BUS_ERR)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        IREQ = 0; DREQ = 0; DWRITE = 0; DSIZE = 0;
        IAD = 0; DAD = 0; DWDT = 0; MRDT = 32'hFFFF_FFFF;
        MACK_n = 1;
        do_reset();
        n_tests++;
        if ({MREQ, MWRITE, MSIZE, ACKI_n, ACKD_n, BUS_ERR} !== 7'b0000110) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000110",
                     {MREQ, MWRITE, MSIZE, ACKI_n, ACKD_n, BUS_ERR});
        end
        n_tests++;
        if ({MAD, MWDT, IDT, DRDT} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {MAD, MWDT, IDT, DRDT});
        end
    endtask

    task automatic test_single_fetch();
        IREQ = 1; IAD = 32'h10;
        tick();
        n_tests++;
        if ({MREQ, MWRITE, MSIZE} !== 4'b1000 || MAD !== 32'h10) begin
            n_fail++;
            $display("FAIL fetch_grant: got req/wr/sz %b mad %h want 1000 10",
                     {MREQ, MWRITE, MSIZE}, MAD);
        end
        MACK_n = 0; MRDT = 32'h513;
        tick();
        n_tests++;
        if (ACKI_n !== 0 || ACKD_n !== 1 || IDT !== 32'h513 || MREQ !== 0) begin
            n_fail++;
            $display("FAIL fetch_ack: got acki %b ackd %b idt %h mreq %b want 0 1 513 0",
                     ACKI_n, ACKD_n, IDT, MREQ);
        end
        IREQ = 0; MACK_n = 1;
        tick();
        n_tests++;
        if (ACKI_n !== 1 || ACKD_n !== 1) begin
            n_fail++;
            $display("FAIL fetch_pulse: got acki %b ackd %b want 1 1", ACKI_n, ACKD_n);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        IREQ = 1; IAD = 32'h100;
        DREQ = 1; DWRITE = 0; DSIZE = 0; DAD = 32'h0800_0000;
        tick();
        n_tests++;
        if (MAD !== 32'h0800_0000 || MREQ !== 1) begin
            n_fail++;
            $display("FAIL conflict_first: got mad %h want 08000000", MAD);
        end
        MACK_n = 0; MRDT = 32'hAAAA;
        tick();
        n_tests++;
        if (ACKD_n !== 0 || ACKI_n !== 1 || DRDT !== 32'hAAAA) begin
            n_fail++;
            $display("FAIL conflict_dack: got ackd %b acki %b drdt %h want 0 1 aaaa",
                     ACKD_n, ACKI_n, DRDT);
        end
        DREQ = 0; MACK_n = 1;
        tick();
        n_tests++;
        if (MREQ !== 0) begin
            n_fail++;
            $display("FAIL conflict_idle_gap: got mreq %b want 0", MREQ);
        end
        tick();
        n_tests++;
        if (MAD !== 32'h100 || MREQ !== 1) begin
            n_fail++;
            $display("FAIL conflict_second: got mad %h want 100", MAD);
        end
        DREQ = 1;
        MACK_n = 0; MRDT = 32'h1111;
        tick();
        n_tests++;
        if (ACKI_n !== 0 || IDT !== 32'h1111) begin
            n_fail++;
            $display("FAIL conflict_iack: got acki %b idt %h want 0 1111", ACKI_n, IDT);
        end
        MACK_n = 1;
        tick();
        tick();
        n_tests++;
        if (MAD !== 32'h0800_0000) begin
            n_fail++;
            $display("FAIL conflict_third: got mad %h want 08000000", MAD);
        end
        MACK_n = 0;
        tick();
        DREQ = 0; MACK_n = 1;
        tick();
        tick();
        n_tests++;
        if (MAD !== 32'h100 || MREQ !== 1) begin
            n_fail++;
            $display("FAIL conflict_fourth: got mad %h want 100", MAD);
        end
        MACK_n = 0;
        tick();
        IREQ = 0; MACK_n = 1;
        tick();
    endtask

    task automatic test_byte_store();
        DREQ = 1; DWRITE = 1; DSIZE = 2'b10;
        DAD = 32'hF000_0000; DWDT = 32'h41;
        tick();
        n_tests++;
        if ({MREQ, MWRITE, MSIZE} !== 4'b1110 || MWDT !== 32'h41
            || MAD !== 32'hF000_0000) begin
            n_fail++;
            $display("FAIL store_grant: got %b mwdt %h mad %h want 1110 41 f0000000",
                     {MREQ, MWRITE, MSIZE}, MWDT, MAD);
        end
        n_tests++;
        if (ACKD_n !== 1) begin
            n_fail++;
            $display("FAIL store_early_ack: got ackd %b want 1", ACKD_n);
        end
        MACK_n = 0; MRDT = 32'h55;
        tick();
        n_tests++;
        if (ACKD_n !== 0 || BUS_ERR !== 0 || DRDT !== 32'h55) begin
            n_fail++;
            $display("FAIL store_ack: got ackd %b berr %b drdt %h want 0 0 55",
                     ACKD_n, BUS_ERR, DRDT);
        end
        DREQ = 0; DWRITE = 0; DSIZE = 0; MACK_n = 1;
        tick();
        n_tests++;
        if (ACKD_n !== 1) begin
            n_fail++;
            $display("FAIL store_pulse: got ackd %b want 1", ACKD_n);
        end
    endtask

    task automatic test_wait_states();
        IREQ = 1; IAD = 32'h200;
        tick();
        for (int k = 1; k <= 6; k++) begin
            n_tests++;
            if (MREQ !== 1 || MAD !== 32'h200 || ACKI_n !== 1 || BUS_ERR !== 0) begin
                n_fail++;
                $display("FAIL wait_stable_%0d: got mreq %b mad %h acki %b berr %b",
                         k, MREQ, MAD, ACKI_n, BUS_ERR);
            end
            if (k == 6) begin
                MACK_n = 0; MRDT = 32'h77;
            end
            tick();
        end
        n_tests++;
        if (ACKI_n !== 0 || BUS_ERR !== 0 || IDT !== 32'h77) begin
            n_fail++;
            $display("FAIL wait_ack: got acki %b berr %b idt %h want 0 0 77",
                     ACKI_n, BUS_ERR, IDT);
        end
        IREQ = 0; MACK_n = 1;
        tick();
    endtask

    task automatic test_timeout();
        DREQ = 1; DWRITE = 0; DAD = 32'h300; MRDT = 32'hDEAD;
        tick();
        for (int k = 1; k <= 16; k++) begin
            n_tests++;
            if (ACKD_n !== 1 || BUS_ERR !== 0 || MREQ !== 1) begin
                n_fail++;
                $display("FAIL tmo_wait_%0d: got ackd %b berr %b mreq %b want 1 0 1",
                         k, ACKD_n, BUS_ERR, MREQ);
            end
            tick();
        end
        n_tests++;
        if (ACKD_n !== 0 || BUS_ERR !== 1 || DRDT !== 0 || MREQ !== 0) begin
            n_fail++;
            $display("FAIL tmo_abort: got ackd %b berr %b drdt %h mreq %b want 0 1 0 0",
                     ACKD_n, BUS_ERR, DRDT, MREQ);
        end
        DREQ = 0;
        tick();
        n_tests++;
        if (ACKD_n !== 1 || BUS_ERR !== 0) begin
            n_fail++;
            $display("FAIL tmo_clear: got ackd %b berr %b want 1 0", ACKD_n, BUS_ERR);
        end
        IREQ = 1; IAD = 32'h400;
        tick();
        MACK_n = 0; MRDT = 32'h99;
        tick();
        n_tests++;
        if (ACKI_n !== 0 || BUS_ERR !== 0 || IDT !== 32'h99) begin
            n_fail++;
            $display("FAIL tmo_next: got acki %b berr %b idt %h want 0 0 99",
                     ACKI_n, BUS_ERR, IDT);
        end
        IREQ = 0; MACK_n = 1;
        tick();
    endtask

    task automatic test_ack_on_timeout_cycle();
        DREQ = 1; DAD = 32'h380;
        tick();
        for (int k = 1; k <= 15; k++) tick();
        MACK_n = 0; MRDT = 32'hBEEF;
        tick();
        n_tests++;
        if (ACKD_n !== 0 || BUS_ERR !== 0 || DRDT !== 32'hBEEF) begin
            n_fail++;
            $display("FAIL edge_ack: got ackd %b berr %b drdt %h want 0 0 beef",
                     ACKD_n, BUS_ERR, DRDT);
        end
        DREQ = 0; MACK_n = 1;
        tick();
    endtask

    task automatic test_idle_ack_ignored();
        MACK_n = 0; MRDT = 32'h1234;
        tick();
        tick();
        n_tests++;
        if (ACKI_n !== 1 || ACKD_n !== 1 || MREQ !== 0 || IDT === 32'h1234) begin
            n_fail++;
            $display("FAIL idle_ack: got acki %b ackd %b mreq %b idt %h",
                     ACKI_n, ACKD_n, MREQ, IDT);
        end
        MACK_n = 1;
    endtask

    task automatic test_reset_mid();
        DREQ = 1; DAD = 32'h500;
        tick();
        tick();
        rst = 0;
        tick();
        n_tests++;
        if (MREQ !== 0 || ACKD_n !== 1 || MAD !== 0) begin
            n_fail++;
            $display("FAIL rstmid_abort: got mreq %b ackd %b mad %h want 0 1 0",
                     MREQ, ACKD_n, MAD);
        end
        rst = 1;
        IREQ = 1; IAD = 32'h600;
        tick();
        n_tests++;
        if (MAD !== 32'h500 || MREQ !== 1 || ACKD_n !== 1) begin
            n_fail++;
            $display("FAIL rstmid_conflict: got mad %h mreq %b want 500 1", MAD, MREQ);
        end
        MACK_n = 0;
        tick();
        DREQ = 0; IREQ = 0; MACK_n = 1;
        tick();
    endtask

    initial begin
        rst = 1;
        test_reset();
        test_single_fetch();
        test_conflict();
        test_byte_store();
        test_wait_states();
        test_timeout();
        test_ack_on_timeout_cycle();
        test_idle_ack_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
